csd_mul_param: RTL and testbench

- Parametrised, operand-latched multiplier using canonical-signed-digit (CSD) recoding.
- Multiplies a W-bit multiplicand by a W-bit multiplier in unsigned or two's-complement mode.
- Skips zero CSD digits, so latency depends on the data.
- Generalises the fixed 16-bit CSD multiplier and is the building block for the reservoir vector-matrix engine.

---
 rtl/csd_mul_pkg.sv | 26 ++
 rtl/csd_recoder.sv | 44 ++++
 rtl/csd_mul_param.sv | 184 ++++++++++++++++++
 tb/tb_csd_mul_param.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csd_mul_pkg.sv
// ---------------------------------------------------------------------------
// csd_mul_pkg
// Shared definitions for the CSD (canonical-signed-digit) multiplier family.
//   state_t         : controller states IDLE -> RECODE -> ACCUM -> DONE
//   DIG_ZERO/POS/NEG: two-bit encoding of one recoded digit {0,+1,-1}
//   csd_max_digits  : worst-case count of nonzero digits for a W-bit
//                     multiplier, (W+2)/2
// ---------------------------------------------------------------------------
package csd_mul_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECODE = 2'd1,
        ACCUM  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_POS  = 2'b01;
    localparam logic [1:0] DIG_NEG  = 2'b11;

    function automatic int csd_max_digits(input int w);
        return (w + 2) / 2;
    endfunction

endpackage

// File: rtl/csd_recoder.sv
// ---------------------------------------------------------------------------
// csd_recoder
// Combinational non-adjacent-form (CSD) recoder for a W-bit operand.
// Parameters:
//   W       operand width
//   SIGNED  1: b is two's complement, 0: b is unsigned
// Ports:
//   b         in  [W-1:0]  operand to recode
//   pos_mask  out [W:0]    digit i is +1 where bit i is set
//   neg_mask  out [W:0]    digit i is -1 where bit i is set
// The two masks are never set at the same index, and no two adjacent
// digits are nonzero.
// ---------------------------------------------------------------------------
module csd_recoder
    import csd_mul_pkg::*;
#(
    parameter int W      = 16,
    parameter int SIGNED = 0
) (
    input  logic [W-1:0] b,
    output logic [W:0]   pos_mask,
    output logic [W:0]   neg_mask
);

    logic [W:0] x_ext;
    logic [W:0] x_half;
    logic [W:0] three_half;
    logic [W:0] diff;

    // NAF via the 3x trick: with h = 3x, the digits are
    // +1 where (h ^ x) & h and -1 where (h ^ x) & x, taken at bit i+1.
    // Only the bits above bit 0 are needed, so work with floor(h/2),
    // which equals x + floor(x/2) and keeps every signal fully used.
    // Arithmetic shift keeps this valid for negative two's complement b.
    always_comb begin
        x_ext      = (SIGNED != 0) ? {b[W-1], b} : {1'b0, b};
        x_half     = {x_ext[W], x_ext[W:1]};
        three_half = x_ext + x_half;
        diff       = three_half ^ x_half;
        pos_mask   = diff & three_half;
        neg_mask   = diff & x_half;
    end

endmodule

// File: rtl/csd_mul_param.sv
// ---------------------------------------------------------------------------
// csd_mul_param
// Operand-latched W x W multiplier that recodes the multiplier b into
// canonical-signed-digit form and performs one shifted add or subtract per
// nonzero digit, so latency depends on the data.
// Parameters:
//   W       operand width (even, >= 4)
//   SIGNED  1: a, b, product are two's complement, 0: unsigned
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start    in   request, accepted only while ready=1 (level sensitive)
//   a        in   [W-1:0]  multiplicand, sampled at the accept edge
//   b        in   [W-1:0]  multiplier, sampled at the accept edge
//   ready    out  high in IDLE only
//   busy     out  high in RECODE and ACCUM
//   done     out  one-cycle pulse when product is updated
//   product  out  [2W-1:0] result, held until next done or reset
// Build option:
//   CSD_MUL_FIXED_LAT_EN  when defined, ACCUM always spends (W+2)/2 digit
//                         slots before finishing, so done always follows
//                         edge (W+2)/2+2 regardless of b.
// ---------------------------------------------------------------------------
module csd_mul_param
    import csd_mul_pkg::*;
#(
    parameter int W      = 16,
    parameter int SIGNED = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int AW = 2 * W + 1;
    localparam int D  = csd_max_digits(W);
    localparam int KW = $clog2(W + 1);

    state_t        state;
    logic [AW-1:0] a_ext;
    logic [AW-1:0] a_in;
    logic [AW-1:0] acc;
    logic [AW-1:0] addend;
    logic [AW-1:0] acc_step;
    logic [W-1:0]  b_lat;
    logic [W:0]    pos_mask;
    logic [W:0]    neg_mask;
    logic [W:0]    rec_pos;
    logic [W:0]    rec_neg;
    logic [W:0]    live;
    logic [W:0]    low;
    logic [KW-1:0] k;
    logic [1:0]    dig;
    logic          any_live;

`ifdef CSD_MUL_FIXED_LAT_EN
    localparam int SW = $clog2(D + 1);
    logic [SW-1:0] slot_cnt;
`endif

    csd_recoder #(
        .W      (W),
        .SIGNED (SIGNED)
    ) u_recoder (
        .b        (b_lat),
        .pos_mask (rec_pos),
        .neg_mask (rec_neg)
    );

    // Operand a is widened once at accept so the accumulator path never
    // has to know about signedness again.
    assign a_in = (SIGNED != 0) ? {{(W + 1){a[W-1]}}, a} : {{(W + 1){1'b0}}, a};

    assign ready = (state == IDLE);
    assign busy  = (state == RECODE) || (state == ACCUM);

    // Digit selection and accumulator step: isolate the lowest remaining
    // nonzero digit, find its index k for the shift, and add or subtract
    // the shifted multiplicand depending on the digit sign.
    always_comb begin
        live     = pos_mask | neg_mask;
        any_live = |live;
        low      = live & (~live + (W + 1)'(1));
        k        = '0;
        for (int i = W; i >= 0; i--) begin
            if (live[i]) begin
                k = KW'(i);
            end
        end
        dig = DIG_ZERO;
        if (|(pos_mask & low)) begin
            dig = DIG_POS;
        end else if (|(neg_mask & low)) begin
            dig = DIG_NEG;
        end
        addend = a_ext << k;
        case (dig)
            DIG_POS: acc_step = acc + addend;
            DIG_NEG: acc_step = acc - addend;
            default: acc_step = acc;
        endcase
    end

    // Controller: latch operands, register the recoded digit masks, then
    // retire one digit per edge until none remain and publish the product.
    // Reset aborts any operation without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            product  <= '0;
            acc      <= '0;
            pos_mask <= '0;
            neg_mask <= '0;
            a_ext    <= '0;
            b_lat    <= '0;
`ifdef CSD_MUL_FIXED_LAT_EN
            slot_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_ext <= a_in;
                        b_lat <= b;
                        state <= RECODE;
                    end
                end
                RECODE: begin
                    pos_mask <= rec_pos;
                    neg_mask <= rec_neg;
                    acc      <= '0;
`ifdef CSD_MUL_FIXED_LAT_EN
                    slot_cnt <= '0;
`endif
                    state    <= ACCUM;
                end
                ACCUM: begin
`ifdef CSD_MUL_FIXED_LAT_EN
                    // Every slot is spent even when no digits remain, so
                    // the finish edge lands at the same place for all b.
                    if (slot_cnt < SW'(D)) begin
                        slot_cnt <= slot_cnt + SW'(1);
                        if (any_live) begin
                            acc      <= acc_step;
                            pos_mask <= pos_mask & ~low;
                            neg_mask <= neg_mask & ~low;
                        end
                    end else begin
                        product <= acc[2*W-1:0];
                        done    <= 1'b1;
                        state   <= DONE;
                    end
`else
                    if (any_live) begin
                        acc      <= acc_step;
                        pos_mask <= pos_mask & ~low;
                        neg_mask <= neg_mask & ~low;
                    end else begin
                        product <= acc[2*W-1:0];
                        done    <= 1'b1;
                        state   <= DONE;
                    end
`endif
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csd_mul_param.sv
// ---------------------------------------------------------------------------
// tb_csd_mul_param
// Self-checking bench for csd_mul_param at W=16. One unsigned and one
// signed instance share clock and reset; each has its own request inputs.
// Honours CSD_MUL_FIXED_LAT_EN when computing the expected latency.
// ---------------------------------------------------------------------------
module tb_csd_mul_param;

    localparam int W = 16;

    typedef struct {
        bit          sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
        int          n;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          start_u, start_s;
    logic [W-1:0]  a_u, b_u, a_s, b_s;
    logic          ready_u, busy_u, done_u;
    logic          ready_s, busy_s, done_s;
    logic [2*W-1:0] product_u, product_s;

    logic          sel_s;
    logic          ready_m, busy_m, done_m;
    logic [2*W-1:0] product_m;

    int testsRun;
    int failCount;

    csd_mul_param #(.W(W), .SIGNED(0)) dut_u (
        .clk     (clk),
        .rst     (rst),
        .start   (start_u),
        .a       (a_u),
        .b       (b_u),
        .ready   (ready_u),
        .busy    (busy_u),
        .done    (done_u),
        .product (product_u)
    );

    csd_mul_param #(.W(W), .SIGNED(1)) dut_s (
        .clk     (clk),
        .rst     (rst),
        .start   (start_s),
        .a       (a_s),
        .b       (b_s),
        .ready   (ready_s),
        .busy    (busy_s),
        .done    (done_s),
        .product (product_s)
    );

    // Outputs of whichever instance the current test is driving
    assign ready_m   = sel_s ? ready_s   : ready_u;
    assign busy_m    = sel_s ? busy_s    : busy_u;
    assign done_m    = sel_s ? done_s    : done_u;
    assign product_m = sel_s ? product_s : product_u;

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count of nonzero NAF digits, derived digit by digit (mod-4 rule)
    function automatic int nafCount(input bit sgn, input logic [15:0] bv);
        int x;
        int n;
        x = sgn ? int'($signed(bv)) : int'({16'h0000, bv});
        n = 0;
        while (x != 0) begin
            if (x[0]) begin
                if ((x & 3) == 3) x = x + 1;
                else              x = x - 1;
                n++;
            end
            x = x >>> 1;
        end
        return n;
    endfunction

    function automatic logic [31:0] refProduct(input bit sgn, input logic [15:0] av, input logic [15:0] bv);
        longint pa;
        longint pb;
        longint p;
        pa = sgn ? longint'($signed(av)) : longint'({48'h0, av});
        pb = sgn ? longint'($signed(bv)) : longint'({48'h0, bv});
        p  = pa * pb;
        return p[31:0];
    endfunction

    function automatic int expLatency(input int n);
        int lat;
        lat = n + 2;
`ifdef CSD_MUL_FIXED_LAT_EN
        lat = (W + 2) / 2 + 2;
`endif
        return lat;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Present one request at a negedge; returns at the negedge after the
    // accept edge (edge 0), dropping start unless hold is set.
    task automatic applyStimulus(input bit sgn, input logic [15:0] av, input logic [15:0] bv, input bit hold);
        @(negedge clk);
        sel_s = sgn;
        if (sgn) begin
            start_s = 1'b1; a_s = av; b_s = bv;
        end else begin
            start_u = 1'b1; a_u = av; b_u = bv;
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            start_u = 1'b0;
            start_s = 1'b0;
        end
    endtask

    // Counts edges after the accept edge until done is seen; -1 on timeout
    task automatic waitDone(input int budget, output int edgeN);
        edgeN = -1;
        for (int e = 1; e <= budget; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_m) begin
                edgeN = e;
                break;
            end
        end
    endtask

    // Done must drop after one cycle and the unit must be ready again
    task automatic checkAfterDone(input string tag, input logic [31:0] prod);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_doneWidth"}, 64'(done_m), 64'd0);
        checkOutput({tag, "_readyBack"}, 64'(ready_m), 64'd1);
        checkOutput({tag, "_held"}, 64'(product_m), 64'(prod));
    endtask

    vec_t vecs[12];

    initial begin
        int lat;
        logic [15:0] ra;
        logic [15:0] rb;
        bit rs;
        bit sawDone;

        testsRun  = 0;
        failCount = 0;

        vecs[0]  = '{0, 16'h0003, 16'h0005, 32'h0000000F, 2};
        vecs[1]  = '{0, 16'hFFFF, 16'h7FFF, 32'h7FFE8001, 2};
        vecs[2]  = '{0, 16'h1234, 16'h0000, 32'h00000000, 0};
        vecs[3]  = '{1, 16'hFFFD, 16'h8000, 32'h00018000, 1};
        vecs[4]  = '{1, 16'h8000, 16'h8000, 32'h40000000, 1};
        vecs[5]  = '{1, 16'h7FFF, 16'hFFFF, 32'hFFFF8001, 1};
        vecs[6]  = '{0, 16'h1234, 16'h0003, 32'h0000369C, 2};
        vecs[7]  = '{0, 16'h00FF, 16'h00FF, 32'h0000FE01, 2};
        vecs[8]  = '{0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 2};
        vecs[9]  = '{1, 16'h0005, 16'hFFFD, 32'hFFFFFFF1, 2};
        vecs[10] = '{0, 16'h0001, 16'h5555, 32'h00005555, 8};
        vecs[11] = '{0, 16'h0003, 16'hAAAB, 32'h00020001, 9};

        rst = 1'b1; sel_s = 1'b0;
        start_u = 1'b0; start_s = 1'b0;
        a_u = '0; b_u = '0; a_s = '0; b_s = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready_u",   64'(ready_u),   64'd1);
        checkOutput("rst_busy_u",    64'(busy_u),    64'd0);
        checkOutput("rst_done_u",    64'(done_u),    64'd0);
        checkOutput("rst_product_u", 64'(product_u), 64'd0);
        checkOutput("rst_ready_s",   64'(ready_s),   64'd1);
        checkOutput("rst_product_s", 64'(product_s), 64'd0);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0);
            checkOutput($sformatf("v%0d_busy", i), 64'(busy_m), 64'd1);
            checkOutput($sformatf("v%0d_notReady", i), 64'(ready_m), 64'd0);
            waitDone(40, lat);
            checkOutput($sformatf("v%0d_latency", i), 64'(lat), 64'(expLatency(vecs[i].n)));
            checkOutput($sformatf("v%0d_product", i), 64'(product_m), 64'(vecs[i].prod));
            checkOutput($sformatf("v%0d_readyInDone", i), 64'(ready_m), 64'd0);
            checkAfterDone($sformatf("v%0d", i), vecs[i].prod);
        end

        // Reset in the middle of an operation: no done, product cleared
        applyStimulus(1'b0, 16'hFFFF, 16'h5555, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_ready",   64'(ready_m),   64'd1);
        checkOutput("abort_busy",    64'(busy_m),    64'd0);
        checkOutput("abort_done",    64'(done_m),    64'd0);
        checkOutput("abort_product", 64'(product_m), 64'd0);
        rst = 1'b0;
        sawDone = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_m) sawDone = 1'b1;
        end
        checkOutput("abort_noDone", 64'(sawDone), 64'd0);
        applyStimulus(1'b0, 16'd7, 16'd9, 1'b0);
        waitDone(40, lat);
        checkOutput("afterAbort_latency", 64'(lat), 64'(expLatency(2)));
        checkOutput("afterAbort_product", 64'(product_m), 64'd63);
        checkAfterDone("afterAbort", 32'd63);

        // start held high: three back-to-back ops, operand changes while
        // busy must not disturb the op in flight
        applyStimulus(1'b0, 16'd2, 16'd3, 1'b1);
        a_u = 16'd4; b_u = 16'd5;
        waitDone(40, lat);
        checkOutput("b2b1_latency", 64'(lat), 64'(expLatency(2)));
        checkOutput("b2b1_product", 64'(product_m), 64'd6);
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b1_doneWidth", 64'(done_m), 64'd0);
        @(posedge clk);
        @(negedge clk);
        a_u = 16'd0; b_u = 16'd9;
        checkOutput("b2b2_busy", 64'(busy_m), 64'd1);
        waitDone(40, lat);
        checkOutput("b2b2_latency", 64'(lat), 64'(expLatency(2)));
        checkOutput("b2b2_product", 64'(product_m), 64'd20);
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b2_doneWidth", 64'(done_m), 64'd0);
        @(posedge clk);
        @(negedge clk);
        start_u = 1'b0;
        waitDone(40, lat);
        checkOutput("b2b3_latency", 64'(lat), 64'(expLatency(2)));
        checkOutput("b2b3_product", 64'(product_m), 64'd0);
        checkAfterDone("b2b3", 32'd0);

        // Random operands in both modes against the reference model
        for (int r = 0; r < 300; r++) begin
            rs = r[0];
            ra = 16'($urandom);
            rb = (r % 17 == 0) ? 16'h0000 : 16'($urandom);
            applyStimulus(rs, ra, rb, 1'b0);
            waitDone(40, lat);
            checkOutput($sformatf("rnd%0d_latency", r), 64'(lat), 64'(expLatency(nafCount(rs, rb))));
            checkOutput($sformatf("rnd%0d_product", r), 64'(product_m), 64'(refProduct(rs, ra, rb)));
            @(posedge clk);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
